spi_slave_rx: RTL

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: 12-bit LSB-first words with optional lead-in bits, valid/ready output handshake.
// Optional macro SPI_RX_FRAME_CHECK_EN enables the sticky frame_err flag for short (aborted) frames.
module spi_slave_rx #(
    parameter int CPHA      = 0,
    parameter int CPOL      = 0,
    parameter int LEAD_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic [11:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        overrun,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, WAIT_CS} state_t;

    state_t      state_q, state_d;
    logic [1:0]  lead_q, lead_d;
    logic [3:0]  bit_q, bit_d;
    logic [11:0] shreg_q, shreg_d;
    logic [11:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;
    logic        sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic        cs_s1_q, cs_s2_q, cs_h_q;
    logic        mosi_s1_q, mosi_s2_q;
    logic [1:0]  vld_q;
    logic        arm_q;
    logic        samp;
    logic        cs_fall;
    logic        word_done;
    logic [11:0] new_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1_q <= 1'(CPOL);
            sclk_s2_q <= 1'(CPOL);
            sclk_h_q  <= 1'(CPOL);
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_h_q    <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            vld_q     <= 2'b00;
            arm_q     <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
            cs_s1_q   <= cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_h_q    <= cs_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
            vld_q     <= {vld_q[0], 1'b1};
            // A start is only accepted once cs_n has been seen high through a filled synchronizer,
            // so a chip select that is already low when reset releases never opens a frame.
            arm_q     <= arm_q | (vld_q[1] & cs_s2_q);
        end
    end

    assign samp     = (CPHA == 0) ? (sclk_h_q & ~sclk_s2_q) : (~sclk_h_q & sclk_s2_q);
    assign cs_fall  = arm_q & cs_h_q & ~cs_s2_q;
    assign new_word = {mosi_s2_q, shreg_q[11:1]};

    always_comb begin
        state_d   = state_q;
        lead_d    = lead_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        word_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    lead_d  = 2'd0;
                    bit_d   = 4'd0;
                    state_d = (LEAD_BITS == 0) ? SHIFT : LEAD;
                end
            end
            LEAD: begin
                if (cs_s2_q) begin
                    state_d = IDLE;
                end else if (samp) begin
                    if (lead_q == 2'(LEAD_BITS - 1)) state_d = SHIFT;
                    else                              lead_d  = lead_q + 2'd1;
                end
            end
            SHIFT: begin
                if (cs_s2_q) begin
                    state_d = IDLE;
                end else if (samp) begin
                    shreg_d = new_word;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd11) begin
                        word_done = 1'b1;
                        state_d   = WAIT_CS;
                    end
                end
            end
            WAIT_CS: begin
                if (cs_s2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && data_ready) valid_d = 1'b0;
        if (word_done) begin
            if (valid_q && !data_ready) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = new_word;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lead_q  <= 2'd0;
            bit_q   <= 4'd0;
            shreg_q <= 12'h000;
            data_q  <= 12'h000;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lead_q  <= lead_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SPI_RX_FRAME_CHECK_EN
    logic ferr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        ferr_q <= 1'b0;
        else if (state_q == SHIFT && cs_s2_q && bit_q != 4'd0) ferr_q <= 1'b1;
    end

    assign frame_err = ferr_q;
`else
    assign frame_err = 1'b0;
`endif

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule
